cache_pmem_arbiter: RTL and testbench
=====================================

Name: cache_pmem_arbiter

Overview:
- Shares one physical-memory line port between the I-cache miss path and the D-cache miss/write-back path of the LC-3b pipeline.
- Sits between the two caches and physical memory.
- Grants exactly one requester at a time, forwards its strobe, address and data, and routes the memory response back to that requester only.
- Sequencing is a 3-state FSM with round-robin or fixed-priority tie-break.

Parameters:
- LINE_W, 128, width of a cache line in bits (pmem data width).
- ADDR_W, 16, address width.
- FIXED_D_PRIO, 0, 0 = round-robin on contention; 1 = D-cache always wins contention.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_pmem_read  in  1  I-cache line-fill request.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_rdata  out  LINE_W  fill data to I-cache.
- i_pmem_resp  out  1  I-cache transaction complete.
- d_pmem_read  in  1  D-cache line-fill request.
- d_pmem_write  in  1  D-cache write-back request.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache write-back data.
- d_pmem_rdata  out  LINE_W  fill data to D-cache.
- d_pmem_resp  out  1  D-cache transaction complete.
- pmem_read  out  1  read strobe to physical memory.
- pmem_write  out  1  write strobe to physical memory.
- pmem_address  out  ADDR_W  address to physical memory.
- pmem_wdata  out  LINE_W  write data to physical memory.
- pmem_rdata  in  LINE_W  read data from physical memory.
- pmem_resp  in  1  physical memory transaction complete.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Internal flag last_grant (I or D).
- Reset (reset==0, async): state=IDLE, last_grant=I, all outputs 0 (strobes, resps, address, wdata, rdata).
- IDLE:
  - pmem_read=pmem_write=0; pmem_address=0; pmem_wdata=0.
  - Next state from sampled requests: i_req=i_pmem_read; d_req=d_pmem_read|d_pmem_write.
  - Only i_req -> SERVE_I. Only d_req -> SERVE_D.
  - Both with FIXED_D_PRIO=1 -> SERVE_D.
  - Both with FIXED_D_PRIO=0 -> the requester not equal to last_grant.
  - Neither -> stay IDLE.
- Grant latency: a request first visible in cycle n (state IDLE) produces the pmem strobe in cycle n+1. Minimum transaction = 2 cycles plus memory latency.
- SERVE_I:
  - pmem_read=i_pmem_read; pmem_write=0; pmem_address=i_pmem_address; pmem_wdata=0.
  - i_pmem_resp=pmem_resp; i_pmem_rdata=pmem_rdata (combinational).
  - d_pmem_resp=0; d_pmem_rdata=0.
- SERVE_D:
  - pmem_address=d_pmem_address; pmem_wdata=d_pmem_wdata.
  - pmem_write=d_pmem_write; pmem_read=d_pmem_read & ~d_pmem_write (write wins if both asserted; illegal but defined).
  - d_pmem_resp=pmem_resp; d_pmem_rdata=pmem_rdata.
  - i_pmem_resp=0; i_pmem_rdata=0.
- Completion: pmem_resp==1 in SERVE_x -> next state IDLE, last_grant=x. The mandatory IDLE cycle lets the requester drop its strobe, so a completed request is never re-granted.
- Abort: granted requester deasserts all strobes in SERVE_x with pmem_resp==0 -> IDLE next cycle, last_grant unchanged, no resp issued.
- Ungranted requester: held pending indefinitely, no side effects; its resp and rdata stay 0.
- pmem_resp in IDLE is ignored (no resp forwarded, no state change).
- Reset mid-transaction: immediate IDLE, strobes drop asynchronously, last_grant=I.
- No width arithmetic: all data paths are pass-through muxes of identical width.

Test Plan:
- I only: i_pmem_read=1, addr=0x1230; memory resps after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 and pmem_address=0x1230 from cycle 1; i_pmem_resp=1 with rdata=0xA5..A5 in the resp cycle; FSM back in IDLE next cycle; D outputs remain 0.
- D write-back: d_pmem_write=1, addr=0x4000, wdata=0x0123..EF -> pmem_write=1, pmem_read=0, pmem_wdata matches; d_pmem_resp is the same cycle as pmem_resp.
- Contention, round-robin: both request in the same cycle after reset -> D served first (last_grant=I). I is served next after exactly one IDLE cycle. Repeat both -> grants alternate D,I,D,I.
- FIXED_D_PRIO=1, both continuously requesting over 3 transactions -> D granted each time, I never granted, i_pmem_resp stays 0.
- Abort: SERVE_D granted, d_pmem_read dropped before pmem_resp -> IDLE next cycle, no d_pmem_resp. A pending I request is granted in the following cycle.
- Async reset: reset=0 mid-SERVE_I, between clock edges -> pmem_read=0 and i_pmem_resp=0 immediately. After release with both requesting -> D granted first.

Source files
------------

// File: rtl/cache_pmem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory line-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the caches/memory side.
interface cache_pmem_arbiter_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache miss paths.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no owner; pmem outputs quiet; picks the next requester
// ST_SERVE_I | I-cache owns pmem; response/rdata routed to I side only
// ST_SERVE_D | D-cache owns pmem; response/rdata routed to D side only
module cache_pmem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int ADDR_W       = 16,
    parameter int FIXED_D_PRIO = 0
) (
    input logic                  clk,
    input logic                  reset,
    cache_pmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SERVE_I, ST_SERVE_D} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;
    logic              w_last_d_nxt;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_pmem_read;
    logic              w_pmem_write;
    logic [ADDR_W-1:0] w_pmem_address;
    logic [LINE_W-1:0] w_pmem_wdata;
    logic [LINE_W-1:0] w_i_rdata;
    logic [LINE_W-1:0] w_d_rdata;
    logic              w_i_resp;
    logic              w_d_resp;

    assign w_i_req = bus.i_pmem_read;
    assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_d_nxt   = r_last_d;
        w_pmem_read    = 1'b0;
        w_pmem_write   = 1'b0;
        w_pmem_address = '0;
        w_pmem_wdata   = '0;
        w_i_rdata      = '0;
        w_i_resp       = 1'b0;
        w_d_rdata      = '0;
        w_d_resp       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On contention round-robin favours whoever was not served last.
                if (w_i_req && w_d_req) begin
                    if (FIXED_D_PRIO != 0 || !r_last_d) w_state_nxt = ST_SERVE_D;
                    else                                w_state_nxt = ST_SERVE_I;
                end else if (w_i_req) begin
                    w_state_nxt = ST_SERVE_I;
                end else if (w_d_req) begin
                    w_state_nxt = ST_SERVE_D;
                end
            end
            ST_SERVE_I: begin
                w_pmem_read    = bus.i_pmem_read;
                w_pmem_address = bus.i_pmem_address;
                w_i_resp       = bus.pmem_resp;
                w_i_rdata      = bus.pmem_rdata;
                if (bus.pmem_resp) begin
                    w_state_nxt  = ST_IDLE;
                    w_last_d_nxt = 1'b0;
                end else if (!w_i_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                // A simultaneous read and write is illegal; the write is honoured.
                w_pmem_write   = bus.d_pmem_write;
                w_pmem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
                w_pmem_address = bus.d_pmem_address;
                w_pmem_wdata   = bus.d_pmem_wdata;
                w_d_resp       = bus.pmem_resp;
                w_d_rdata      = bus.pmem_rdata;
                if (bus.pmem_resp) begin
                    w_state_nxt  = ST_IDLE;
                    w_last_d_nxt = 1'b1;
                end else if (!w_d_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_address;
    assign bus.pmem_wdata   = w_pmem_wdata;
    assign bus.i_pmem_rdata = w_i_rdata;
    assign bus.i_pmem_resp  = w_i_resp;
    assign bus.d_pmem_rdata = w_d_rdata;
    assign bus.d_pmem_resp  = w_d_resp;
endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Bench for cache_pmem_arbiter: vector table, directed corner sequences and a randomized
// run against an ownership-based reference model for both tie-break modes.
module tb_cache_pmem_arbiter;
    localparam int LW = 128;
    localparam int AW = 16;
    localparam logic [AW-1:0] I_ADDR = 16'h1230;
    localparam logic [AW-1:0] D_ADDR = 16'h4000;
    localparam logic [LW-1:0] RDATA  = {16{8'hA5}};
    localparam logic [LW-1:0] WDATA  = {2{64'h0123456789ABCDEF}};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_pmem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus0 ();
    cache_pmem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus1 ();

    cache_pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FIXED_D_PRIO(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    cache_pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FIXED_D_PRIO(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    // The fixed-priority instance sees exactly the same stimulus.
    assign bus1.i_pmem_read    = bus0.i_pmem_read;
    assign bus1.i_pmem_address = bus0.i_pmem_address;
    assign bus1.d_pmem_read    = bus0.d_pmem_read;
    assign bus1.d_pmem_write   = bus0.d_pmem_write;
    assign bus1.d_pmem_address = bus0.d_pmem_address;
    assign bus1.d_pmem_wdata   = bus0.d_pmem_wdata;
    assign bus1.pmem_rdata     = bus0.pmem_rdata;
    assign bus1.pmem_resp      = bus0.pmem_resp;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pack(input logic pr, input logic pw, input logic [AW-1:0] addr,
                                          input logic [LW-1:0] wd, input logic ir,
                                          input logic [LW-1:0] ird, input logic dr,
                                          input logic [LW-1:0] drd);
        return 512'({pr, pw, addr, wd, ir, ird, dr, drd});
    endfunction

    task automatic drive(input logic ir, input logic dr, input logic dw, input logic resp);
        bus0.i_pmem_read  = ir;
        bus0.d_pmem_read  = dr;
        bus0.d_pmem_write = dw;
        bus0.pmem_resp    = resp;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        bus0.i_pmem_address = I_ADDR;
        bus0.d_pmem_address = D_ADDR;
        bus0.d_pmem_wdata   = WDATA;
        bus0.pmem_rdata     = RDATA;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Vector table: inputs for one cycle and the expected RR-instance outputs in that cycle.
    // sel: 0 = nobody owns pmem, 1 = I owns, 2 = D owns.
    typedef struct {
        logic ir, dr, dw, resp;
        int   sel;
        logic epr, epw, eir, edr;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic ir, input logic dr, input logic dw, input logic resp,
                                input int sel, input logic epr, input logic epw,
                                input logic eir, input logic edr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.resp = resp;
        v.sel = sel; v.epr = epr; v.epw = epw; v.eir = eir; v.edr = edr;
        vecs.push_back(v);
    endfunction

    // Reference model: who owns memory and who was last served to completion.
    int owner  [2];
    bit last_d [2];

    function automatic logic [511:0] model_out(input int k);
        logic pr = 0, pw = 0, ir = 0, dr = 0;
        logic [AW-1:0] addr = '0;
        logic [LW-1:0] wd = '0, ird = '0, drd = '0;
        if (owner[k] == 1) begin
            pr = bus0.i_pmem_read; addr = bus0.i_pmem_address;
            ir = bus0.pmem_resp;   ird  = bus0.pmem_rdata;
        end else if (owner[k] == 2) begin
            pw = bus0.d_pmem_write;
            pr = bus0.d_pmem_read && !bus0.d_pmem_write;
            addr = bus0.d_pmem_address; wd = bus0.d_pmem_wdata;
            dr = bus0.pmem_resp;        drd = bus0.pmem_rdata;
        end
        return pack(pr, pw, addr, wd, ir, ird, dr, drd);
    endfunction

    function automatic void model_step(input int k, input bit fixed);
        bit i_req = bus0.i_pmem_read;
        bit d_req = bus0.d_pmem_read || bus0.d_pmem_write;
        if (owner[k] == 0) begin
            if (i_req && d_req) owner[k] = (fixed || !last_d[k]) ? 2 : 1;
            else if (i_req)     owner[k] = 1;
            else if (d_req)     owner[k] = 2;
        end else if (bus0.pmem_resp) begin
            last_d[k] = (owner[k] == 2);
            owner[k]  = 0;
        end else if ((owner[k] == 1 && !i_req) || (owner[k] == 2 && !d_req)) begin
            owner[k] = 0;
        end
    endfunction

    initial begin
        // Reset with every input active: all outputs must be quiet.
        reset = 1'b0;
        bus0.i_pmem_address = I_ADDR;
        bus0.d_pmem_address = D_ADDR;
        bus0.d_pmem_wdata   = WDATA;
        bus0.pmem_rdata     = RDATA;
        drive(1, 1, 1, 1);
        @(negedge clk);
        check("reset_out_rr", pack(bus0.pmem_read, bus0.pmem_write, bus0.pmem_address,
              bus0.pmem_wdata, bus0.i_pmem_resp, bus0.i_pmem_rdata, bus0.d_pmem_resp,
              bus0.d_pmem_rdata), '0);
        check("reset_out_fx", pack(bus1.pmem_read, bus1.pmem_write, bus1.pmem_address,
              bus1.pmem_wdata, bus1.i_pmem_resp, bus1.i_pmem_rdata, bus1.d_pmem_resp,
              bus1.d_pmem_rdata), '0);

        //   ir dr dw rs sel pr pw ir dr
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);  // I-only fill
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);  // D write-back
        add(0, 0, 1, 0, 2, 0, 1, 0, 0);
        add(0, 0, 1, 1, 2, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);  // contention, last served D -> I first
        add(1, 1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 2, 1, 0, 0, 0);
        add(1, 1, 0, 1, 2, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2, 1, 0, 0, 1);  // minimum-length transaction
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);  // resp while idle is ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);  // D abort with I pending
        add(1, 1, 0, 0, 2, 1, 0, 0, 0);
        add(1, 0, 0, 0, 2, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);  // read+write together: write wins
        add(0, 1, 1, 0, 2, 0, 1, 0, 0);
        add(0, 1, 1, 1, 2, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);  // I abort keeps last grant = D
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[n]) begin
            drive(vecs[n].ir, vecs[n].dr, vecs[n].dw, vecs[n].resp);
            @(negedge clk);
            check($sformatf("vec%0d_ctl", n),
                  512'({bus0.pmem_read, bus0.pmem_write, bus0.i_pmem_resp, bus0.d_pmem_resp}),
                  512'({vecs[n].epr, vecs[n].epw, vecs[n].eir, vecs[n].edr}));
            check($sformatf("vec%0d_addr", n), 512'(bus0.pmem_address),
                  512'(vecs[n].sel == 1 ? I_ADDR : vecs[n].sel == 2 ? D_ADDR : '0));
            check($sformatf("vec%0d_wdata", n), 512'(bus0.pmem_wdata),
                  512'(vecs[n].sel == 2 ? WDATA : '0));
            check($sformatf("vec%0d_irdata", n), 512'(bus0.i_pmem_rdata),
                  512'(vecs[n].sel == 1 ? RDATA : '0));
            check($sformatf("vec%0d_drdata", n), 512'(bus0.d_pmem_rdata),
                  512'(vecs[n].sel == 2 ? RDATA : '0));
            @(posedge clk);
            #1;
        end

        // Fixed D priority: both request continuously; memory answers at once.
        begin
            int d_done = 0;
            do_reset();
            drive(1, 1, 0, 0);
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                bus0.pmem_resp = bus1.pmem_read;
                @(negedge clk);
                check("fixed_no_iresp", 512'(bus1.i_pmem_resp), 512'(0));
                if (bus1.pmem_read) check("fixed_addr_is_d", 512'(bus1.pmem_address), 512'(D_ADDR));
                if (bus1.d_pmem_resp) d_done++;
            end
            check("fixed_d_count", 512'(d_done), 512'(6));
            drive(0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of an I transaction.
        do_reset();
        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        bus0.pmem_resp = 1'b1;
        #1;
        check("areset_pre", 512'({bus0.pmem_read, bus0.i_pmem_resp}), 512'(2'b11));
        #1;
        reset = 1'b0;
        #1;
        check("areset_drop", 512'({bus0.pmem_read, bus0.i_pmem_resp}), 512'(2'b00));
        drive(1, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("areset_after_d", 512'({bus0.pmem_read, bus0.pmem_address, bus0.i_pmem_resp}),
              512'({1'b1, D_ADDR, 1'b0}));

        // Randomized run against the reference model, both tie-break modes.
        do_reset();
        owner[0] = 0; owner[1] = 0; last_d[0] = 0; last_d[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            bus0.i_pmem_read    = ($urandom_range(0, 9) < 6);
            bus0.d_pmem_read    = ($urandom_range(0, 9) < 4);
            bus0.d_pmem_write   = ($urandom_range(0, 9) < 3);
            bus0.pmem_resp      = ($urandom_range(0, 9) < 3);
            bus0.i_pmem_address = AW'($urandom);
            bus0.d_pmem_address = AW'($urandom);
            bus0.d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            bus0.pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check($sformatf("rand%0d_rr", c), pack(bus0.pmem_read, bus0.pmem_write,
                  bus0.pmem_address, bus0.pmem_wdata, bus0.i_pmem_resp, bus0.i_pmem_rdata,
                  bus0.d_pmem_resp, bus0.d_pmem_rdata), model_out(0));
            check($sformatf("rand%0d_fx", c), pack(bus1.pmem_read, bus1.pmem_write,
                  bus1.pmem_address, bus1.pmem_wdata, bus1.i_pmem_resp, bus1.i_pmem_rdata,
                  bus1.d_pmem_resp, bus1.d_pmem_rdata), model_out(1));
            @(posedge clk);
            model_step(0, 1'b0);
            model_step(1, 1'b1);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
